// File: rtl/apu_pkg.sv
// Shared APU definitions for the channel-1 sweep/frequency slice.
// Holds the datapath widths, the period-timer wrap value and the bundle of
// sweep command strobes that channel1 issues to the sweep unit.
package apu_pkg;

  localparam int unsigned FREQ_W = 11;
  localparam int unsigned SUM_W  = 12;
  localparam logic [FREQ_W-1:0] TIMER_MAX = 11'h7FF;

  typedef struct packed {
    logic restart;
    logic ld_shift;
    logic shift_clk;
    logic upd1;
    logic upd2;
  } sweep_cmd_t;

endpackage

// File: rtl/ch1_sweep_shifter.sv
// Channel-1 sweep shifter, adder and overflow flag.
// Only built when CH1_SWEEP_EN is defined (instantiated by ch1_sweep_freq).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cmd         : sweep command strobes (restart, ld_shift, shift_clk, upd1, upd2)
//   sweep_neg   : 1 = subtract shifted value from shadow
//   shadow      : current shadow frequency
//   sum_lo      : low 11 bits of shadow +/- shifter
//   ovf         : combinational overflow of the current sum
//   ovf_q       : overflow registered on upd1/upd2, cleared on restart
module ch1_sweep_shifter
  import apu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  sweep_cmd_t        cmd,
  input  logic              sweep_neg,
  input  logic [FREQ_W-1:0] shadow,
  output logic [FREQ_W-1:0] sum_lo,
  output logic              ovf,
  output logic              ovf_q
);

  logic [FREQ_W-1:0] shifter_q, shifter_d;
  logic              shift_clk_q, shift_clk_d;
  logic              ovf_d;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    // Subtraction underflow simply wraps; ovf is only meaningful for add.
    if (sweep_neg) sum = {1'b0, shadow} - {1'b0, shifter_q};
    else           sum = {1'b0, shadow} + {1'b0, shifter_q};
    sum_lo = sum[FREQ_W-1:0];
    ovf    = !sweep_neg && sum[SUM_W-1];

    shift_clk_d = cmd.shift_clk;

    shifter_d = shifter_q;
    if (cmd.ld_shift) begin
      shifter_d = shadow;
    end else if (cmd.upd2 && !cmd.restart) begin
      // shadow already carries the upd1 result, so this re-arms the re-check
      shifter_d = shadow;
    end else if (cmd.shift_clk && !shift_clk_q) begin
      shifter_d = shifter_q >> 1;
    end

    ovf_d = ovf_q;
    if (cmd.restart)                 ovf_d = 1'b0;
    else if (cmd.upd1 || cmd.upd2)   ovf_d = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter_q   <= '0;
      shift_clk_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      shifter_q   <= shifter_d;
      shift_clk_q <= shift_clk_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: rtl/ch1_sweep_freq.sv
// Channel-1 frequency register, sweep shadow and period timer.
// Optional sweep datapath enabled by macro CH1_SWEEP_EN; without it atys is
// tied high and the sweep command inputs are ignored.
// Ports:
//   ajer_2mhz   : clock (rising edge)
//   napu_reset  : asynchronous active-low reset
//   d           : CPU write data; apu_wr with ff13/ff14 writes NR13/NR14
//   sweep_neg   : NR10 bit 3, 1 = subtract
//   tick_en     : period-timer advance enable
//   ch1_*       : sweep commands from channel1
//   atys        : high = no sweep overflow
//   cate        : one-cycle pulse on each period-timer wrap
//   freq        : current frequency register
module ch1_sweep_freq
  import apu_pkg::*;
(
  input  logic        ajer_2mhz,
  input  logic        napu_reset,
  input  logic [7:0]  d,
  input  logic        apu_wr,
  input  logic        ff13,
  input  logic        ff14,
  input  logic        sweep_neg,
  input  logic        tick_en,
  input  logic        ch1_restart,
  input  logic        ch1_ld_shift,
  input  logic        ch1_shift_clk,
  input  logic        ch1_freq_upd1,
  input  logic        ch1_freq_upd2,
  output logic        atys,
  output logic        cate,
  output logic [10:0] freq
);

  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [FREQ_W-1:0] timer_q, timer_d;
  logic              cate_q, cate_d;
  logic [FREQ_W-1:0] sum_lo;
  logic              upd_ok;
  logic              wr13, wr14;

`ifdef CH1_SWEEP_EN
  sweep_cmd_t cmd;
  logic       ovf;
  logic       ovf_q;

  always_comb begin
    cmd.restart   = ch1_restart;
    cmd.ld_shift  = ch1_ld_shift;
    cmd.shift_clk = ch1_shift_clk;
    cmd.upd1      = ch1_freq_upd1;
    cmd.upd2      = ch1_freq_upd2;
  end

  ch1_sweep_shifter u_shifter (
    .clk       (ajer_2mhz),
    .rst_n     (napu_reset),
    .cmd       (cmd),
    .sweep_neg (sweep_neg),
    .shadow    (shadow_q),
    .sum_lo    (sum_lo),
    .ovf       (ovf),
    .ovf_q     (ovf_q)
  );

  assign upd_ok = ch1_freq_upd1 && !ovf && !ch1_restart;
  assign atys   = !ovf_q;
`else
  logic unused_sweep;
  assign unused_sweep = &{1'b0, sweep_neg, ch1_ld_shift, ch1_shift_clk,
                          ch1_freq_upd1, ch1_freq_upd2};
  assign sum_lo = '0;
  assign upd_ok = 1'b0;
  assign atys   = 1'b1;
`endif

  assign wr13 = apu_wr && ff13;
  assign wr14 = apu_wr && ff14;

  always_comb begin
    // CPU byte writes land after the sweep result so they win per byte.
    freq_d = freq_q;
    if (upd_ok) freq_d = sum_lo;
    if (wr13)   freq_d[7:0]  = d;
    if (wr14)   freq_d[10:8] = d[2:0];

    shadow_d = shadow_q;
    if (ch1_restart) shadow_d = freq_q;
    else if (upd_ok) shadow_d = sum_lo;

    timer_d = timer_q;
    cate_d  = 1'b0;
    if (ch1_restart) begin
      timer_d = freq_q;
    end else if (tick_en) begin
      if (timer_q == TIMER_MAX) begin
        timer_d = shadow_q;
        cate_d  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ajer_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      freq_q   <= '0;
      shadow_q <= '0;
      timer_q  <= '0;
      cate_q   <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      shadow_q <= shadow_d;
      timer_q  <= timer_d;
      cate_q   <= cate_d;
    end
  end

  assign cate = cate_q;
  assign freq = freq_q;

endmodule

// File: doc/ch1_sweep_freq.md
CH1_SWEEP_FREQ -- requirements
Module: ch1_sweep_freq

Interface
REQ-001 SHALL have port ajer_2mhz, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port napu_reset, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port d, input, 8: CPU write data.
REQ-004 SHALL have ports apu_wr, ff13 and ff14, inputs, 1 each: write strobe and NR13/NR14 selects; a write occurs when the strobe and a select are both high in the same cycle.
REQ-005 SHALL have port sweep_neg, input, 1: NR10 bit 3; 1 = subtract.
REQ-006 SHALL have port tick_en, input, 1: period-timer advance enable, one cycle per 1 MHz period.
REQ-007 SHALL have ports ch1_restart, ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1 and ch1_freq_upd2, inputs, 1 each: sweep commands issued by channel1.
REQ-008 SHALL have port atys, output, 1: high = no sweep overflow; low terminates ch1.
REQ-009 SHALL have port cate, output, 1: one-cycle pulse on each period-timer wrap; it clocks the ch1 duty logic.
REQ-010 SHALL have port freq, output, 11: current frequency register.

Function
REQ-011 SHALL load freq[7:0] from d on an NR13 write and freq[10:8] from d[2:0] on an NR14 write.
REQ-012 SHALL copy freq into shadow[10:0] on the cycle after ch1_restart is high.
REQ-013 SHALL, while ch1_ld_shift is high, load shifter[10:0] from shadow every cycle.
REQ-014 SHALL shift the shifter right by one on each rising edge of ch1_shift_clk, detected with a registered copy; ld_shift has priority.
REQ-015 SHALL compute sum[11:0] combinationally as shadow+shifter, or shadow-shifter when sweep_neg is 1, zero-extended.
REQ-016 SHALL define ovf = !sweep_neg && sum[11] and drive atys = !ovf_q, where ovf_q is ovf registered on ch1_freq_upd1 or ch1_freq_upd2.
REQ-017 SHALL, on ch1_freq_upd1 with ovf = 0, write sum[10:0] into both freq and shadow; with ovf = 1 both are unchanged.
REQ-018 SHALL, on ch1_freq_upd2, reload the shifter from the updated shadow so the overflow re-check follows; freq is not written.
REQ-019 SHALL give a same-cycle NR13/NR14 CPU write priority over upd1 for the written freq byte; shadow still takes sum.
REQ-020 SHALL, on ch1_restart, take priority over upd1/upd2 and clear ovf_q to 0.
REQ-021 SHALL implement the period timer as an 11-bit up-counter advanced when tick_en is high.
REQ-022 SHALL, when the timer advances at 0x7FF, reload it from shadow and pulse cate high for exactly one cycle.
REQ-023 SHALL, on ch1_restart, load the timer from freq.
REQ-024 SHALL produce cate latency of (2048 - shadow) tick_en pulses; shadow 0x7FF pulses cate on every tick_en.
REQ-025 SHALL let subtraction underflow wrap modulo 2^12 with ovf = 0; only sum[10:0] is used.

Reset
REQ-026 SHALL, while napu_reset is low, hold freq, shadow, shifter, timer, ovf_q and the edge register at 0, atys = 1 and cate = 0, regardless of other inputs.
REQ-027 SHALL abort any operation in progress on a reset assertion mid-sweep; after release the first command acts on zeroed state.

Configuration
REQ-028 SHALL, with macro CH1_SWEEP_EN defined, implement the full sweep datapath per REQ-013..REQ-020.
REQ-029 SHALL, without CH1_SWEEP_EN, omit shifter, adder and ovf_q: atys tied 1, upd/ld/shift inputs ignored, shadow still loaded on restart, timer unchanged.

Structure
REQ-030 SHALL place FREQ_W=11, SUM_W=12, TIMER_MAX=11'h7FF and the sweep command struct type in shared package apu_pkg.
REQ-031 SHALL put shifter, adder and overflow flag in one sub-module ch1_sweep_shifter, removed whole when CH1_SWEEP_EN is undefined.

Verification
REQ-032 SHALL cover add: freq=0x400, restart, ld_shift, 1 shift_clk edge, upd1 -> freq=0x600, atys=1.
REQ-033 SHALL cover subtract: sweep_neg=1, freq=0x400, 1 shift -> upd1 -> freq=0x200, atys=1.
REQ-034 SHALL cover overflow: freq=0x700, 1 shift (sum 0xA80), upd1 -> atys=0, freq stays 0x700; next restart -> atys=1.
REQ-035 SHALL cover the timer: freq=0x7FE, restart, tick_en every cycle -> cate pulses every 2nd tick_en, each 1 cycle wide.
REQ-036 SHALL cover collision: NR13 write d=0x55 in the same cycle as upd1 (sum 0x600) -> freq=0x655, shadow=0x600.
REQ-037 SHALL cover reset: napu_reset low mid-sweep -> all state 0, atys=1, cate=0 immediately, without a clock edge.
